// File: rtl/io_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the shared I/O bus.
// "master" is the requester/bus-device side; "slave" is the arbiter side.
interface io_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              m0_req;
    logic              m0_wr;
    logic              m0_lock;
    logic [DATA_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_wr;
    logic              m1_lock;
    logic [DATA_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [DATA_W-1:0] io_addr;
    logic [DATA_W-1:0] io_dout;
    logic              io_rd;
    logic              io_wr;
    logic [DATA_W-1:0] io_din;

    // Handshake: a master holds mN_req and its command fields stable until it
    // sees mN_gnt; a transaction completes in the cycle mN_gnt is high. Read
    // data returns one cycle later with a single-cycle mN_rvalid pulse.
    modport master (
        output m0_req, m0_wr, m0_lock, m0_addr, m0_wdata,
        output m1_req, m1_wr, m1_lock, m1_addr, m1_wdata,
        output io_din,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  io_addr, io_dout, io_rd, io_wr
    );

    modport slave (
        input  m0_req, m0_wr, m0_lock, m0_addr, m0_wdata,
        input  m1_req, m1_wr, m1_lock, m1_addr, m1_wdata,
        input  io_din,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output io_addr, io_dout, io_rd, io_wr
    );
endinterface

// File: rtl/io_arbiter.sv
// Two-master arbiter for the shared 16-bit I/O bus: fixed priority to m0,
// aging override for m1, per-master bus lock with idle timeout.
module io_arbiter #(
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4,
    parameter int LOCK_TMO = 16
) (
    input  logic        clk,
    input  logic        reset,
    io_arbiter_if.slave bus,
    output logic        lock_err,
    output logic [1:0]  lock_state
);
    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int TW = $clog2(LOCK_TMO + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TMO - 1);

    state_t            state;
    logic [WW-1:0]     wait_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic              gnt0;
    logic              gnt1;
    logic              owner_req;
    logic              tmo_fire;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    // Grant is gated by reset so bus strobes drop the moment reset asserts.
    always_comb begin
        owner_req = (state == LOCK1) ? bus.m1_req : bus.m0_req;
        tmo_fire  = (state != FREE) && !owner_req && (tmo_cnt == TMO_LAST);
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (!reset) begin
            case (state)
                FREE: begin
                    if (bus.m1_req && (wait_cnt >= WAIT_MAX)) gnt1 = 1'b1;
                    else if (bus.m0_req)                      gnt0 = 1'b1;
                    else if (bus.m1_req)                      gnt1 = 1'b1;
                end
                LOCK0:   gnt0 = bus.m0_req;
                LOCK1:   gnt1 = bus.m1_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.io_rd   = (gnt0 & ~bus.m0_wr) | (gnt1 & ~bus.m1_wr);
        bus.io_wr   = (gnt0 & bus.m0_wr) | (gnt1 & bus.m1_wr);
        bus.io_addr = '0;
        bus.io_dout = '0;
        if (gnt0) begin
            bus.io_addr = bus.m0_addr;
            bus.io_dout = bus.m0_wdata;
        end else if (gnt1) begin
            bus.io_addr = bus.m1_addr;
            bus.io_dout = bus.m1_wdata;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rvalid0;
    assign bus.m1_rvalid = rvalid1;
    assign bus.m0_rdata  = rdata0;
    assign bus.m1_rdata  = rdata1;
    assign lock_err      = tmo_fire;
    assign lock_state    = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= gnt0 & ~bus.m0_wr;
            rvalid1 <= gnt1 & ~bus.m1_wr;
            if (gnt0 && !bus.m0_wr) rdata0 <= bus.io_din;
            if (gnt1 && !bus.m1_wr) rdata1 <= bus.io_din;
        end
    end

    // Aging for m1 counts while it is blocked, including while m0 holds a lock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!bus.m1_req || gnt1) begin
            wait_cnt <= '0;
        end else if (wait_cnt < WAIT_MAX) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Lock FSM; tmo_cnt only counts owner-idle cycles while locked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FREE;
            tmo_cnt <= '0;
        end else begin
            case (state)
                FREE: begin
                    tmo_cnt <= '0;
                    if (gnt0 && bus.m0_lock)      state <= LOCK0;
                    else if (gnt1 && bus.m1_lock) state <= LOCK1;
                end
                LOCK0: begin
                    if (tmo_fire || (gnt0 && !bus.m0_lock)) begin
                        state   <= FREE;
                        tmo_cnt <= '0;
                    end else if (bus.m0_req) begin
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                LOCK1: begin
                    if (tmo_fire || (gnt1 && !bus.m1_lock)) begin
                        state   <= FREE;
                        tmo_cnt <= '0;
                    end else if (bus.m1_req) begin
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: begin
                    state   <= FREE;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end
endmodule
